// File: rtl/ecc_tb_pkg.sv
// Shared types and mask-building helpers for the ECC bench error channel.
// Mask helpers take widths as arguments so one package serves any codeword size.
package ecc_tb_pkg;

  typedef enum logic [1:0] {
    ECC_CH_PASS     = 2'd0,
    ECC_CH_EXPLICIT = 2'd1,
    ECC_CH_RANDOM   = 2'd2,
    ECC_CH_BURST    = 2'd3
  } ecc_ch_mode_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int unsigned MASK_MAX  = 256;
  localparam int unsigned FLIPS_MAX = 8;

  typedef logic [MASK_MAX-1:0] mask_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [8:0] popcount(input mask_t m);
    logic [8:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MASK_MAX; i++) cnt = cnt + 9'(m[i]);
    return cnt;
  endfunction

  function automatic logic [31:0] slot(input logic [31:0] pos, input int unsigned k,
                                       input int unsigned posw);
    logic [31:0] fld;
    fld = (32'h1 << posw) - 32'h1;
    return (pos >> (k * posw)) & fld;
  endfunction

  function automatic mask_t onehot(input logic [31:0] p);
    return mask_t'(1) << p;
  endfunction

  function automatic mask_t mask_pass();
    return '0;
  endfunction

  // Duplicates are OR-ed so a repeated position flips its bit only once.
  function automatic mask_t mask_explicit(input logic [31:0] pos, input int unsigned c,
                                          input int unsigned w, input int unsigned posw);
    mask_t m;
    logic [31:0] p;
    m = '0;
    for (int unsigned k = 0; k < FLIPS_MAX; k++) begin
      if (k < c) begin
        p = slot(pos, k, posw);
        if (p < w) m = m | onehot(p);
      end
    end
    return m;
  endfunction

  function automatic mask_t mask_random(input logic [31:0] lfsr, input int unsigned c,
                                        input int unsigned w, input int unsigned posw);
    mask_t m;
    logic [31:0] p;
    m = '0;
    for (int unsigned k = 0; k < FLIPS_MAX; k++) begin
      if (k < c) begin
        p = slot(lfsr, k, posw);
        if (p >= w) p = p - w;
        if (p < w) m = m | onehot(p);
      end
    end
    return m;
  endfunction

  function automatic mask_t mask_burst(input logic [31:0] pos, input int unsigned c,
                                       input int unsigned w, input int unsigned posw);
    mask_t m;
    logic [31:0] p0, p;
    m  = '0;
    p0 = slot(pos, 0, posw);
    if (p0 < w) begin
      for (int unsigned k = 0; k < FLIPS_MAX; k++) begin
        if (k < c) begin
          p = p0 + k;
          if (p >= w) p = p - w;
          m = m | onehot(p);
        end
      end
    end
    return m;
  endfunction

  function automatic mask_t build_mask(input ecc_ch_mode_e mode, input logic [31:0] pos,
                                       input logic [31:0] lfsr, input int unsigned c,
                                       input int unsigned w, input int unsigned posw);
    case (mode)
      ECC_CH_EXPLICIT: return mask_explicit(pos, c, w, posw);
      ECC_CH_RANDOM:   return mask_random(lfsr, c, w, posw);
      ECC_CH_BURST:    return mask_burst(pos, c, w, posw);
      default:         return mask_pass();
    endcase
  endfunction

endpackage

// File: rtl/ecc_tb_err_channel_lfsr.sv
// 32-bit Galois LFSR with seed load; a zero seed or SEED is replaced by 1.
module ecc_tb_lfsr
  import ecc_tb_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        step_i,
  input  logic        ld_i,
  input  logic [31:0] seed_i,
  output logic [31:0] q_o
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     lfsr_q <= SEED_EFF;
    else if (ld_i)   lfsr_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
    else if (step_i) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/ecc_tb_err_channel.sv
// Error-injection channel between Hamming encoder and decoder: corrupts each
// word at acceptance, carries data+mask down a stallable pipeline, keeps stats.
module ecc_tb_err_channel
  import ecc_tb_pkg::*;
#(
  parameter int          n         = 8,
  parameter int          MAX_FLIPS = 4,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    mode_i,
  input  logic [3:0]                    nflips_i,
  input  logic [MAX_FLIPS*$clog2(n+1)-1:0] pos_i,
  input  logic                          seed_ld_i,
  input  logic [31:0]                   seed_i,
  input  logic                          clr_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [n:0]                    d_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [n:0]                    q_o,
  output logic [n:0]                    mask_o,
  output logic [3:0]                    nflips_o,
  output logic [31:0]                   word_cnt_o,
  output logic [31:0]                   flip_cnt_o
);

  localparam int unsigned W    = n + 1;
  localparam int unsigned POSW = $clog2(n + 1);
  localparam logic [31:0] MAXF = 32'(MAX_FLIPS);

  if (MAX_FLIPS < 1 || MAX_FLIPS > 8) begin : g_bad_flips
    $error("MAX_FLIPS must be 1..8");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_lat
    $error("LATENCY must be 1..8");
  end
  if (MAX_FLIPS * POSW > 32) begin : g_bad_posw
    $error("MAX_FLIPS*POSW must fit in 32 bits");
  end
  if (MAX_FLIPS > W || W > MASK_MAX) begin : g_bad_w
    $error("codeword width out of range");
  end

  logic [LATENCY-1:0] v_q, free;
  logic [n:0]         q_q    [LATENCY];
  logic [n:0]         mask_q [LATENCY];
  logic [3:0]         nfl_q  [LATENCY];
  logic               f, accept, step, xfer;
  logic [31:0]        lfsr, nreq, cnt_eff;
  mask_t              mask_full;
  logic [n:0]         mask_new;
  logic [3:0]         nfl_new;
  logic [31:0]        word_cnt_q, word_cnt_d, flip_cnt_q, flip_cnt_d;
  logic [32:0]        flip_sum;

  // A stage may load if it is empty or its occupant moves on this edge.
  always_comb begin
    free = '0;
    f    = !v_q[LATENCY-1] || ready_i;
    free[LATENCY-1] = f;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      f       = !v_q[k] || f;
      free[k] = f;
    end
  end

  assign ready_o = free[0];
  assign accept  = valid_i && free[0];
  assign step    = accept && (mode_i == ECC_CH_RANDOM);
  assign nreq    = 32'(nflips_i);
  assign cnt_eff = (nreq > MAXF) ? MAXF : nreq;

  always_comb begin
    mask_full = build_mask(ecc_ch_mode_e'(mode_i), 32'(pos_i), lfsr, cnt_eff, W, POSW);
    mask_new  = mask_full[n:0];
    nfl_new   = 4'(popcount(mask_full));
  end

  ecc_tb_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .step_i (step),
    .ld_i   (seed_ld_i),
    .seed_i (seed_i),
    .q_o    (lfsr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        q_q[k]    <= '0;
        mask_q[k] <= '0;
        nfl_q[k]  <= '0;
      end
    end else begin
      if (free[0]) begin
        v_q[0] <= accept;
        if (accept) begin
          q_q[0]    <= d_i ^ mask_new;
          mask_q[0] <= mask_new;
          nfl_q[0]  <= nfl_new;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (free[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            q_q[k]    <= q_q[k-1];
            mask_q[k] <= mask_q[k-1];
            nfl_q[k]  <= nfl_q[k-1];
          end
        end
      end
    end
  end

  assign xfer = v_q[LATENCY-1] && ready_i;

  always_comb begin
    flip_sum   = {1'b0, flip_cnt_q} + 33'(nfl_q[LATENCY-1]);
    word_cnt_d = word_cnt_q;
    flip_cnt_d = flip_cnt_q;
    if (clr_i) begin
      word_cnt_d = '0;
      flip_cnt_d = '0;
    end else if (xfer) begin
      word_cnt_d = (word_cnt_q == 32'hFFFF_FFFF) ? word_cnt_q : word_cnt_q + 32'h1;
      flip_cnt_d = flip_sum[32] ? 32'hFFFF_FFFF : flip_sum[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_q <= '0;
      flip_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end

  assign valid_o    = v_q[LATENCY-1];
  assign q_o        = q_q[LATENCY-1];
  assign mask_o     = mask_q[LATENCY-1];
  assign nflips_o   = nfl_q[LATENCY-1];
  assign word_cnt_o = word_cnt_q;
  assign flip_cnt_o = flip_cnt_q;

endmodule

// File: doc/ecc_tb_err_channel.md
Name: ecc_tb_err_channel

Overview:
- Parametrised error-injection channel for the Hamming encoder/decoder benches.
- Sits between the encoder output and the decoder input.
- Corrupts 0..MAX_FLIPS codeword bits per word in one of four modes: pass, explicit positions, LFSR-random, burst.
- Has a valid/ready pipeline with stall support, reports the error mask actually applied for each word, and keeps word/flip statistics for the scoreboard.

Parameters:
- n, 8: codeword msb index; codeword width W=n+1.
- MAX_FLIPS, 4: maximum bits corrupted per word (1..8).
- LATENCY, 1: pipeline stages (1..8).
- SEED, 32'h1: LFSR reset value (0 is replaced by 1).
- Derived localparam POSW=$clog2(W).
- Elaboration check: MAX_FLIPS*POSW<=32.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- mode_i  in  2  0=PASS, 1=EXPLICIT, 2=RANDOM, 3=BURST; sampled with each accepted word.
- nflips_i  in  4  requested flips; values >MAX_FLIPS saturate to MAX_FLIPS.
- pos_i  in  MAX_FLIPS*POSW  flattened flip positions; slot k = pos_i[k*POSW+:POSW].
- seed_ld_i  in  1  load seed_i into LFSR (seed_i=0 loads 1).
- seed_i  in  32  LFSR seed.
- clr_i  in  1  synchronous clear of statistics counters.
- valid_i  in  1  input word valid.
- ready_o  out  1  channel can accept.
- d_i  in  W  clean codeword.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts.
- q_o  out  W  corrupted codeword = d^mask.
- mask_o  out  W  error mask applied to q_o.
- nflips_o  out  4  popcount(mask_o).
- word_cnt_o  out  32  words transferred at output.
- flip_cnt_o  out  32  total bits flipped at output.

Behaviour:
- Reset (async assert, sync release): all stage valids 0; q_o, mask_o, nflips_o, counters 0; LFSR=SEED (SEED=0 gives 1).
- Accept on valid_i&&ready_o; transfer on valid_o&&ready_i.
- Mask is computed combinationally at acceptance and stored in stage 0. It travels with the data.
- Latency: a word accepted at edge t appears on q_o after edge t+LATENCY-1 when no stall occurs. LATENCY=1 gives the old channel's single-register timing.
- Pipeline: stage k loads when it is empty or stage k+1 loads/transfers. Bubbles collapse.
- ready_o = !stage0_valid || stage0 advancing. With ready_i held high, throughput is 1 word/clock.
- Stalled outputs hold q_o/mask_o/nflips_o stable.
- Effective count c = min(nflips_i, MAX_FLIPS).
- PASS: mask=0 regardless of nflips_i.
- EXPLICIT: mask = OR of onehot(pos slot k) for k<c.
  - Positions >=W are ignored.
  - Duplicate positions flip once (no XOR cancel).
- RANDOM: slot k position = lfsr[k*POSW+:POSW]; values >=W reduce by subtracting W.
  - Mask is built with the same OR rule, so collisions reduce nflips_o below c.
  - LFSR is a 32-bit Galois LFSR, taps 32,22,2,1 (ecc_tb_pkg::LFSR_POLY).
  - Steps once per accepted word in RANDOM mode only. Idle clocks and other modes leave it unchanged.
- BURST: bits pos slot0, slot0+1, .. slot0+c-1, taken modulo W (wraps from n to 0).
  - slot0 >= W gives mask=0.
  - c>W is impossible, since MAX_FLIPS<=W is checked at elaboration.
- Seed load: seed_ld_i has priority over a simultaneous RANDOM step. The word accepted in that cycle uses the pre-load LFSR value.
- Counters: on each output transfer, word_cnt += 1 and flip_cnt += nflips_o. Both saturate at 32'hFFFF_FFFF.
  - clr_i has priority over a same-cycle increment.
- Reset mid-stream: in-flight words are discarded. No partial output.

Decomposition:
- Package ecc_tb_pkg holds:
  - the mode enum (ECC_CH_PASS, ECC_CH_EXPLICIT, ECC_CH_RANDOM, ECC_CH_BURST);
  - LFSR_POLY;
  - the popcount function;
  - a mask-build function per mode.
- Sub-module ecc_tb_lfsr holds the 32-bit LFSR.
  - Ports: clk_i, rst_ni, step_i, ld_i, seed_i, q_o.
  - Parameter: SEED.
  - Is reused by future benches.

Test Plan:
- n=8, LATENCY=1, PASS, d=9'h1A5, ready_i=1 -> q_o=9'h1A5 one clock after accept, mask_o=0, nflips_o=0, word_cnt=1.
- EXPLICIT, nflips_i=2, slots {3,3}, d=0 -> mask_o=9'h008, nflips_o=1. Then slots {0,8} -> q_o=9'h101, nflips_o=2.
- BURST, nflips_i=3, slot0=7, d=0 -> mask_o=9'h181 (bits 7,8,0), nflips_o=3. Then nflips_i=9 -> saturates to 4, mask=9'h183.
- LATENCY=3, 4 back-to-back words, ready_i low for 5 clocks after the first two are accepted:
  - ready_o drops once 3 stages are full;
  - q_o holds while stalled;
  - order is preserved;
  - word_cnt=4 at the end.
- RANDOM, seed_ld_i with seed_i=0 -> LFSR=1. 100 words -> masks match the ecc_tb_pkg reference model, and flip_cnt equals the sum of nflips_o.
- Assert rst_ni low mid-stream with 2 words in flight -> valid_o=0 immediately, counters=0, LFSR=SEED. The first word after release has normal latency.
